l2_ctrl_regs_p: RTL and testbench

Parametrised control/status register bank for the Spandex L2 controller. Replaces the fixed-width L2 register set.
- MSHR credit counter with simultaneous alloc/free and sticky error detection.
- N independent forward-stall trackers.
- Generic set/clear flag vector.
- Self-sequencing flush walker FSM.
Sits beside the L2 FSM, which drives its triggers and reads its state every cycle.

---
 rtl/l2_ctrl_regs_pkg.sv | 25 ++
 rtl/l2_ctrl_regs_p_fwd.sv | 39 +++
 rtl/l2_ctrl_regs_p.sv | 216 +++++++++++++++++++++
 tb/tb_l2_ctrl_regs_p.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_ctrl_regs_pkg.sv
// Shared constants and types for the L2 controller register bank.
// Flag bit map, flush walker states and default sizes.
package l2_ctrl_regs_pkg;

  localparam int FLAG_EVICT_STALL  = 0;
  localparam int FLAG_SET_CONFLICT = 1;
  localparam int FLAG_FENCE        = 2;
  localparam int FLAG_DRAIN        = 3;
  localparam int FLAG_ATOMIC       = 4;
  localparam int FLAG_FLUSH        = 5;

  localparam int DEF_N_MSHR   = 16;
  localparam int DEF_N_FWD_CH = 2;
  localparam int DEF_N_FLAGS  = 6;
  localparam int DEF_L2_SETS  = 256;
  localparam int DEF_L2_WAYS  = 8;
  localparam int DEF_N_WB     = 4;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_WALK,
    FL_DONE
  } flush_state_t;

endpackage

// File: rtl/l2_ctrl_regs_p_fwd.sv
// Single forward-stall tracker: arms on an MSHR index and
// records when that MSHR is freed.
module l2_fwd_tracker
  import l2_ctrl_regs_pkg::*;
#(
  parameter int MB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic [MB-1:0] set_entry,
  input  logic          clr,
  input  logic          free,
  input  logic [MB-1:0] free_idx,
  output logic          stall,
  output logic [MB-1:0] entry,
  output logic          ended
);

  // clear beats arm, arm beats end detection on the held index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall <= 1'b0;
      entry <= '0;
      ended <= 1'b0;
    end else if (clr) begin
      stall <= 1'b0;
      entry <= '0;
      ended <= 1'b0;
    end else if (set) begin
      stall <= 1'b1;
      entry <= set_entry;
      ended <= 1'b0;
    end else if (free && stall && (entry == free_idx)) begin
      ended <= 1'b1;
    end
  end

endmodule

// File: rtl/l2_ctrl_regs_p.sv
// Parametrised L2 controller control/status register bank.
// Optional write-buffer counters enabled by L2_CTRL_REGS_WB_EN.
module l2_ctrl_regs_p
  import l2_ctrl_regs_pkg::*;
#(
  parameter int N_MSHR   = DEF_N_MSHR,
  parameter int N_FWD_CH = DEF_N_FWD_CH,
  parameter int N_FLAGS  = DEF_N_FLAGS,
  parameter int L2_SETS  = DEF_L2_SETS,
  parameter int L2_WAYS  = DEF_L2_WAYS,
`ifdef L2_CTRL_REGS_WB_EN
  parameter int N_WB     = DEF_N_WB,
  parameter int WBB      = $clog2(N_WB),
`endif
  parameter int MB       = $clog2(N_MSHR),
  parameter int SB       = $clog2(L2_SETS),
  parameter int WB       = $clog2(L2_WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mshr_alloc,
  input  logic                   mshr_free,
  input  logic [MB-1:0]          mshr_free_idx,
  output logic [MB:0]            mshr_cnt,
  output logic                   mshr_full,
  output logic                   mshr_err,
  input  logic [N_FLAGS-1:0]     flag_set,
  input  logic [N_FLAGS-1:0]     flag_clr,
  output logic [N_FLAGS-1:0]     flags,
  input  logic [N_FWD_CH-1:0]    fwd_set,
  input  logic [N_FWD_CH*MB-1:0] fwd_set_entry,
  input  logic [N_FWD_CH-1:0]    fwd_clr,
  output logic [N_FWD_CH-1:0]    fwd_stall,
  output logic [N_FWD_CH*MB-1:0] fwd_entry,
  output logic [N_FWD_CH-1:0]    fwd_ended,
  input  logic                   flush_start,
  input  logic                   flush_step,
  input  logic                   flush_abort,
  output logic [SB-1:0]          flush_set,
  output logic [WB-1:0]          flush_way,
  output logic                   flush_busy,
  output logic                   flush_done
`ifdef L2_CTRL_REGS_WB_EN
  ,
  input  logic                   wb_add,
  input  logic                   wb_hit,
  input  logic                   wb_clear,
  output logic [WBB:0]           wb_cnt,
  output logic [WBB-1:0]         wb_evict_ptr
`endif
);

  localparam logic [MB:0]   CNT_MAX  = (MB+1)'(N_MSHR);
  localparam logic [MB:0]   CNT_ONE  = (MB+1)'(1);
  localparam logic [SB-1:0] SET_LAST = SB'(L2_SETS - 1);
  localparam logic [SB-1:0] SET_ONE  = SB'(1);
  localparam logic [WB-1:0] WAY_LAST = WB'(L2_WAYS - 1);
  localparam logic [WB-1:0] WAY_ONE  = WB'(1);

  flush_state_t fl_state;
  logic         mshr_bad;
  logic         wb_bad;

  assign mshr_full = (mshr_cnt == '0);

  // a lone alloc at empty or a lone free at full is an error
  always_comb begin
    mshr_bad = 1'b0;
    if (mshr_alloc && !mshr_free && (mshr_cnt == '0))
      mshr_bad = 1'b1;
    if (mshr_free && !mshr_alloc && (mshr_cnt == CNT_MAX))
      mshr_bad = 1'b1;
  end

  // credit counter; simultaneous alloc and free cancel out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mshr_cnt <= CNT_MAX;
    end else if (!mshr_bad) begin
      if (mshr_alloc && !mshr_free)
        mshr_cnt <= mshr_cnt - CNT_ONE;
      else if (mshr_free && !mshr_alloc)
        mshr_cnt <= mshr_cnt + CNT_ONE;
    end
  end

  // sticky error shared by MSHR and write-buffer counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mshr_err <= 1'b0;
    else if (mshr_bad || wb_bad)
      mshr_err <= 1'b1;
  end

  // per-bit flags, clear wins over set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flags <= '0;
    else
      flags <= (flags | flag_set) & ~flag_clr;
  end

  for (genvar c = 0; c < N_FWD_CH; c++) begin : g_fwd
    l2_fwd_tracker #(
      .MB(MB)
    ) u_trk (
      .clk      (clk),
      .rst      (rst),
      .set      (fwd_set[c]),
      .set_entry(fwd_set_entry[c*MB +: MB]),
      .clr      (fwd_clr[c]),
      .free     (mshr_free),
      .free_idx (mshr_free_idx),
      .stall    (fwd_stall[c]),
      .entry    (fwd_entry[c*MB +: MB]),
      .ended    (fwd_ended[c])
    );
  end

  // flush walker: ways inner, sets outer, abort always wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_state   <= FL_IDLE;
      flush_set  <= '0;
      flush_way  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else if (flush_abort) begin
      fl_state   <= FL_IDLE;
      flush_set  <= '0;
      flush_way  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      unique case (fl_state)
        FL_IDLE: begin
          flush_done <= 1'b0;
          if (flush_start) begin
            fl_state   <= FL_WALK;
            flush_set  <= '0;
            flush_way  <= '0;
            flush_busy <= 1'b1;
          end
        end
        FL_WALK: begin
          if (flush_step) begin
            if (flush_way != WAY_LAST) begin
              flush_way <= flush_way + WAY_ONE;
            end else begin
              flush_way <= '0;
              if (flush_set == SET_LAST) begin
                fl_state   <= FL_DONE;
                flush_done <= 1'b1;
              end else begin
                flush_set <= flush_set + SET_ONE;
              end
            end
          end
        end
        FL_DONE: begin
          fl_state   <= FL_IDLE;
          flush_done <= 1'b0;
          flush_busy <= 1'b0;
        end
        default: begin
          fl_state   <= FL_IDLE;
          flush_busy <= 1'b0;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef L2_CTRL_REGS_WB_EN
  localparam logic [WBB:0]   WB_MAX  = (WBB+1)'(N_WB);
  localparam logic [WBB:0]   WB_ONE  = (WBB+1)'(1);
  localparam logic [WBB-1:0] PTR_END = WBB'(N_WB - 1);
  localparam logic [WBB-1:0] PTR_ONE = WBB'(1);

  logic wb_dec;
  assign wb_dec = wb_add && !wb_hit;

  // write-buffer counter limits feed the shared error flag
  always_comb begin
    wb_bad = 1'b0;
    if (wb_dec && !wb_clear && (wb_cnt == '0))
      wb_bad = 1'b1;
    if (wb_clear && !wb_dec && (wb_cnt == WB_MAX))
      wb_bad = 1'b1;
  end

  // free write-buffer slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_cnt <= WB_MAX;
    end else if (!wb_bad) begin
      if (wb_dec && !wb_clear)
        wb_cnt <= wb_cnt - WB_ONE;
      else if (wb_clear && !wb_dec)
        wb_cnt <= wb_cnt + WB_ONE;
    end
  end

  // round-robin evict pointer, frozen while draining
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wb_evict_ptr <= '0;
    else if (wb_clear && !flags[FLAG_DRAIN])
      wb_evict_ptr <= (wb_evict_ptr == PTR_END) ? '0
                    : wb_evict_ptr + PTR_ONE;
  end
`else
  assign wb_bad = 1'b0;
`endif

endmodule

// File: tb/tb_l2_ctrl_regs_p.sv
// Testbench for l2_ctrl_regs_p: directed tables and sequences,
// then random traffic against a behavioural model.
module tb_l2_ctrl_regs_p;

  localparam int NM   = 16;
  localparam int NC   = 2;
  localparam int NF   = 6;
  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int MB   = 4;
  localparam int SB   = 2;
  localparam int WB   = 1;
  localparam int TOT  = SETS * WAYS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mshr_alloc, mshr_free;
  logic [MB-1:0] mshr_free_idx;
  logic [MB:0] mshr_cnt;
  logic mshr_full, mshr_err;
  logic [NF-1:0] flag_set, flag_clr, flags;
  logic [NC-1:0] fwd_set, fwd_clr, fwd_stall, fwd_ended;
  logic [NC*MB-1:0] fwd_set_entry, fwd_entry;
  logic flush_start, flush_step, flush_abort;
  logic [SB-1:0] flush_set;
  logic [WB-1:0] flush_way;
  logic flush_busy, flush_done;
`ifdef L2_CTRL_REGS_WB_EN
  logic wb_add, wb_hit, wb_clear;
  logic [2:0] wb_cnt;
  logic [1:0] wb_evict_ptr;
`endif

  l2_ctrl_regs_p #(
    .N_MSHR(NM), .N_FWD_CH(NC), .N_FLAGS(NF),
    .L2_SETS(SETS), .L2_WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .mshr_alloc(mshr_alloc), .mshr_free(mshr_free),
    .mshr_free_idx(mshr_free_idx), .mshr_cnt(mshr_cnt),
    .mshr_full(mshr_full), .mshr_err(mshr_err),
    .flag_set(flag_set), .flag_clr(flag_clr), .flags(flags),
    .fwd_set(fwd_set), .fwd_set_entry(fwd_set_entry),
    .fwd_clr(fwd_clr), .fwd_stall(fwd_stall),
    .fwd_entry(fwd_entry), .fwd_ended(fwd_ended),
    .flush_start(flush_start), .flush_step(flush_step),
    .flush_abort(flush_abort), .flush_set(flush_set),
    .flush_way(flush_way), .flush_busy(flush_busy),
    .flush_done(flush_done)
`ifdef L2_CTRL_REGS_WB_EN
    , .wb_add(wb_add), .wb_hit(wb_hit), .wb_clear(wb_clear),
    .wb_cnt(wb_cnt), .wb_evict_ptr(wb_evict_ptr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_cnt;
  bit m_err;
  bit [NF-1:0] m_flags;
  bit m_stall [NC];
  int m_entry [NC];
  bit m_ended [NC];
  int m_phase;
  int m_k;

  typedef struct {
    logic [NF-1:0] s;
    logic [NF-1:0] c;
    logic [NF-1:0] exp;
  } flag_vec_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = NM;
    m_err = 0;
    m_flags = '0;
    for (int c = 0; c < NC; c++) begin
      m_stall[c] = 0;
      m_entry[c] = 0;
      m_ended[c] = 0;
    end
    m_phase = 0;
    m_k = 0;
  endtask

  task automatic model_step();
    if (mshr_alloc && !mshr_free) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end else if (mshr_free && !mshr_alloc) begin
      if (m_cnt == NM) m_err = 1;
      else m_cnt++;
    end
    for (int b = 0; b < NF; b++) begin
      if (flag_clr[b]) m_flags[b] = 0;
      else if (flag_set[b]) m_flags[b] = 1;
    end
    for (int c = 0; c < NC; c++) begin
      if (fwd_clr[c]) begin
        m_stall[c] = 0;
        m_entry[c] = 0;
        m_ended[c] = 0;
      end else if (fwd_set[c]) begin
        m_stall[c] = 1;
        m_entry[c] = int'(fwd_set_entry[c*MB +: MB]);
        m_ended[c] = 0;
      end else if (mshr_free && m_stall[c] &&
                   m_entry[c] == int'(mshr_free_idx)) begin
        m_ended[c] = 1;
      end
    end
    if (flush_abort) begin
      m_phase = 0;
      m_k = 0;
    end else if (m_phase == 0) begin
      if (flush_start) begin
        m_phase = 1;
        m_k = 0;
      end
    end else if (m_phase == 1) begin
      if (flush_step) begin
        m_k++;
        if (m_k == TOT) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic clr_in();
    mshr_alloc = 0; mshr_free = 0; mshr_free_idx = '0;
    flag_set = '0; flag_clr = '0;
    fwd_set = '0; fwd_clr = '0; fwd_set_entry = '0;
    flush_start = 0; flush_step = 0; flush_abort = 0;
`ifdef L2_CTRL_REGS_WB_EN
    wb_add = 0; wb_hit = 0; wb_clear = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 0;
    model_reset();
    #13;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic check_model(string tag);
    int es, ew;
    logic [NC-1:0] xs, xe;
    logic [NC*MB-1:0] xn;
    es = (m_k == TOT) ? SETS - 1 : m_k / WAYS;
    ew = (m_k == TOT) ? 0 : m_k % WAYS;
    for (int c = 0; c < NC; c++) begin
      xs[c] = m_stall[c];
      xe[c] = m_ended[c];
      xn[c*MB +: MB] = MB'(m_entry[c]);
    end
    chk({tag, ".cnt"}, 32'(mshr_cnt), 32'(m_cnt));
    chk({tag, ".full"}, 32'(mshr_full), 32'(m_cnt == 0));
    chk({tag, ".err"}, 32'(mshr_err), 32'(m_err));
    chk({tag, ".flags"}, 32'(flags), 32'(m_flags));
    chk({tag, ".stall"}, 32'(fwd_stall), 32'(xs));
    chk({tag, ".entry"}, 32'(fwd_entry), 32'(xn));
    chk({tag, ".ended"}, 32'(fwd_ended), 32'(xe));
    chk({tag, ".fset"}, 32'(flush_set), 32'(es));
    chk({tag, ".fway"}, 32'(flush_way), 32'(ew));
    chk({tag, ".busy"}, 32'(flush_busy), 32'(m_phase != 0));
    chk({tag, ".done"}, 32'(flush_done), 32'(m_phase == 2));
  endtask

  initial begin
    flag_vec_t fv [6];
    int pulses;
    bit hi;

    fv[0] = '{6'b000100, 6'b000100, 6'b000000};
    fv[1] = '{6'b000100, 6'b000000, 6'b000100};
    fv[2] = '{6'b000000, 6'b000000, 6'b000100};
    fv[3] = '{6'b101001, 6'b000100, 6'b101001};
    fv[4] = '{6'b000010, 6'b100000, 6'b001011};
    fv[5] = '{6'b000000, 6'b111111, 6'b000000};

    // reset values
    do_reset();
    chk("rst.cnt", 32'(mshr_cnt), 16);
    chk("rst.full", 32'(mshr_full), 0);
    chk("rst.err", 32'(mshr_err), 0);
    chk("rst.flags", 32'(flags), 0);
    chk("rst.stall", 32'(fwd_stall), 0);
    chk("rst.entry", 32'(fwd_entry), 0);
    chk("rst.ended", 32'(fwd_ended), 0);
    chk("rst.fset", 32'(flush_set), 0);
    chk("rst.fway", 32'(flush_way), 0);
    chk("rst.busy", 32'(flush_busy), 0);
    chk("rst.done", 32'(flush_done), 0);

    // drain all credits then underflow
    mshr_alloc = 1;
    for (int i = 0; i < 16; i++) tick();
    chk("alloc16.cnt", 32'(mshr_cnt), 0);
    chk("alloc16.full", 32'(mshr_full), 1);
    chk("alloc16.err", 32'(mshr_err), 0);
    tick();
    chk("alloc17.cnt", 32'(mshr_cnt), 0);
    chk("alloc17.err", 32'(mshr_err), 1);
    mshr_alloc = 0;
    mshr_free = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("free5.cnt", 32'(mshr_cnt), 5);
    mshr_alloc = 1;
    tick();
    chk("both.cnt", 32'(mshr_cnt), 5);
    chk("both.err", 32'(mshr_err), 1);
    clr_in();

    // forward tracker channel 1
    fwd_set = 2'b10;
    fwd_set_entry = {4'd7, 4'd0};
    tick();
    clr_in();
    chk("fwd.stall", 32'(fwd_stall), 2);
    chk("fwd.entry1", 32'(fwd_entry[7:4]), 7);
    mshr_free = 1;
    mshr_free_idx = 4'd3;
    tick();
    chk("fwd.miss", 32'(fwd_ended), 0);
    mshr_free_idx = 4'd7;
    tick();
    chk("fwd.hit", 32'(fwd_ended), 2);
    clr_in();
    tick();
    chk("fwd.hold", 32'(fwd_ended), 2);
    fwd_clr = 2'b10;
    tick();
    clr_in();
    chk("fwd.clr.stall", 32'(fwd_stall), 0);
    chk("fwd.clr.entry", 32'(fwd_entry), 0);
    chk("fwd.clr.ended", 32'(fwd_ended), 0);

    // flag vector table
    for (int i = 0; i < 6; i++) begin
      flag_set = fv[i].s;
      flag_clr = fv[i].c;
      tick();
      chk($sformatf("flag%0d", i), 32'(flags), 32'(fv[i].exp));
    end
    clr_in();

    // full flush walk
    flush_start = 1;
    tick();
    flush_start = 0;
    chk("fl.start.busy", 32'(flush_busy), 1);
    pulses = 0;
    for (int i = 0; i < TOT; i++) begin
      chk($sformatf("fl.pos%0d", i),
          {30'd0, flush_set}, 32'(i / WAYS));
      chk($sformatf("fl.way%0d", i),
          {31'd0, flush_way}, 32'(i % WAYS));
      flush_step = 1;
      tick();
      if (flush_done) pulses++;
    end
    flush_step = 0;
    chk("fl.done", 32'(flush_done), 1);
    chk("fl.done.busy", 32'(flush_busy), 1);
    chk("fl.end.set", 32'(flush_set), SETS - 1);
    chk("fl.end.way", 32'(flush_way), 0);
    tick();
    if (flush_done) pulses++;
    chk("fl.after.busy", 32'(flush_busy), 0);
    chk("fl.after.set", 32'(flush_set), SETS - 1);
    tick();
    if (flush_done) pulses++;
    chk("fl.pulses", 32'(pulses), 1);

    // abort mid-walk, start while walking is ignored
    flush_start = 1;
    tick();
    flush_start = 0;
    flush_step = 1;
    for (int i = 0; i < 3; i++) tick();
    flush_step = 0;
    flush_start = 1;
    tick();
    flush_start = 0;
    chk("ab.ign.set", 32'(flush_set), 1);
    chk("ab.ign.way", 32'(flush_way), 1);
    flush_abort = 1;
    tick();
    flush_abort = 0;
    pulses = 0;
    chk("ab.busy", 32'(flush_busy), 0);
    chk("ab.set", 32'(flush_set), 0);
    chk("ab.way", 32'(flush_way), 0);
    for (int i = 0; i < 4; i++) begin
      if (flush_done) pulses++;
      tick();
    end
    chk("ab.nodone", 32'(pulses), 0);

    // random traffic against the model
    do_reset();
    check_model("rnd0");
    for (int i = 0; i < 3000; i++) begin
      hi = ((i / 250) % 2) == 0;
      mshr_alloc = $urandom_range(0, 9) < (hi ? 7 : 2);
      mshr_free = $urandom_range(0, 9) < (hi ? 2 : 7);
      mshr_free_idx = MB'($urandom_range(0, 15));
      flag_set = NF'($urandom & $urandom);
      flag_clr = NF'($urandom & $urandom & $urandom);
      for (int c = 0; c < NC; c++) begin
        fwd_set[c] = $urandom_range(0, 15) == 0;
        fwd_clr[c] = $urandom_range(0, 19) == 0;
        fwd_set_entry[c*MB +: MB] = MB'($urandom_range(0, 15));
      end
      flush_start = $urandom_range(0, 5) == 0;
      flush_step = $urandom_range(0, 1) == 1;
      flush_abort = $urandom_range(0, 59) == 0;
      tick();
      check_model("rnd");
    end
    clr_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
